// File: rtl/async_counter_pkg.sv
// rtl/async_counter_pkg.sv - shared width defaults, count type and Gray conversion for async_counter
package async_counter_pkg;

  localparam int COUNT_W_DEFAULT = 4;
  localparam int COUNT_W_MAX     = 32;

  typedef logic [COUNT_W_DEFAULT-1:0] count_t;

  // Callers zero-extend into COUNT_W_MAX bits and truncate the result to their width.
  function automatic logic [COUNT_W_MAX-1:0] bin2gray(input logic [COUNT_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/counter_bit_slice.sv
// rtl/counter_bit_slice.sv - one toggle stage of the synchronous counter carry chain
module counter_bit_slice (
  input  logic clk,
  input  logic rst,
  input  logic carry_in,
  output logic q,
  output logic carry_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (carry_in) begin
      q <= ~q;
    end
  end

  assign carry_out = carry_in & q;

endmodule

// File: rtl/async_counter.sv
// rtl/async_counter.sv - free-running up-counter clocked by next, async active-high clear
// Optional ASYNC_COUNTER_GRAY_EN presents a registered Gray-coded count.
module async_counter
  import async_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W_DEFAULT
) (
  input  logic             next,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] bin;
  logic             carry_unused;

  assign carry[0]     = 1'b1;
  assign carry_unused = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    counter_bit_slice u_slice (
      .clk       (next),
      .rst       (rst),
      .carry_in  (carry[i]),
      .q         (bin[i]),
      .carry_out (carry[i+1])
    );
  end

`ifdef ASYNC_COUNTER_GRAY_EN
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_q;

  // The carry chain is exactly the toggle mask, so this is bin+1 without a separate adder.
  assign bin_next = bin ^ carry[WIDTH-1:0];

  always_ff @(posedge next or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= WIDTH'(bin2gray(COUNT_W_MAX'(bin_next)));
    end
  end

  assign count = gray_q;
`else
  assign count = bin;
`endif

endmodule

// File: tb/tb_async_counter.sv
// tb/tb_async_counter.sv - randomized scoreboard bench for async_counter (binary or ASYNC_COUNTER_GRAY_EN)
module tb_async_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         next;
  logic         rst;
  logic [W-1:0] count;

  async_counter #(.WIDTH(W)) dut (
    .next  (next),
    .rst   (rst),
    .count (count)
  );

  typedef struct {
    logic [W-1:0] val;
    string        name;
    bit           is_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          in_reset = 1'b1;
  int unsigned edges    = 0;

`ifdef ASYNC_COUNTER_GRAY_EN
  localparam logic [3:0] GRAY_TAB [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`endif

  // Reference: count is the number of qualifying edges since the last release, modulo 2^W.
  function automatic logic [W-1:0] model_val(int unsigned n);
    int unsigned v;
    v = n % MOD;
`ifdef ASYNC_COUNTER_GRAY_EN
    return GRAY_TAB[v];
`else
    return W'(v);
`endif
  endfunction

  task automatic push(string nm, bit is_edge);
    exp_t e;
    e.val     = in_reset ? '0 : model_val(edges);
    e.name    = nm;
    e.is_edge = is_edge;
    exp_q.push_back(e);
  endtask

  task automatic rise(string nm);
    next = 1'b1;
    if (!in_reset) edges++;
    push(nm, !in_reset);
    #5;
  endtask

  task automatic fall(string nm);
    next = 1'b0;
    push(nm, 1'b0);
    #5;
  endtask

  task automatic do_reset(string nm);
    rst <= 1'b1;
    in_reset = 1'b1;
    edges    = 0;
    push(nm, 1'b0);
    #5;
  endtask

  task automatic do_release(string nm);
    rst <= 1'b0;
    in_reset = 1'b0;
    push(nm, 1'b0);
    #5;
  endtask

  // rst falls via NBA so the coincident next edge still sees reset asserted.
  task automatic do_coincident(string nm);
    next = 1'b1;
    rst <= 1'b0;
    in_reset = 1'b0;
    push(nm, 1'b0);
    #5;
  endtask

  initial begin : monitor
    exp_t         e;
    logic [W-1:0] prev;
    prev = '0;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (count !== e.val) begin
        failures++;
        $display("FAIL %s: count=%0d expected=%0d", e.name, count, e.val);
      end
`ifdef ASYNC_COUNTER_GRAY_EN
      if (e.is_edge) begin
        checks++;
        if ($countones(count ^ prev) != 1) begin
          failures++;
          $display("FAIL %s_hamming: prev=%0d now=%0d distance=%0d required=1",
                   e.name, prev, count, $countones(count ^ prev));
        end
      end
`endif
      prev = count;
    end
  end

  initial begin : driver
    int r;
    next = 1'b0;
    rst <= 1'b1;
    #2;
    push("reset_state", 1'b0);
    #5;

    rise("reset_edge_ignored");
    fall("reset_edge_fall");

    do_release("release");
    for (int i = 0; i < 5; i++) begin
      rise("count_up");
      fall("count_fall");
    end

    do_reset("async_clear_mid_count");
    do_release("release2");
    for (int i = 0; i < 17; i++) begin
      rise("wrap");
      fall("wrap_fall");
    end

    do_reset("reset_before_coincident");
    do_coincident("coincident_release");
    fall("coincident_fall");
    rise("after_coincident");
    fall("after_coincident_fall");

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 24));
      if (in_reset) begin
        if (r < 12) do_release("rand_release");
        else begin
          do_coincident("rand_coincident");
          fall("rand_coincident_fall");
        end
      end else if (r == 0) begin
        do_reset("rand_reset");
      end else begin
        rise("rand_rise");
        fall("rand_fall");
      end
    end

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
